// File: rtl/config_shift_engine.sv
// Serial configuration shifter: optional chip reset pulse, MSB-first bit-banged
// frame on p_sck/p_sda, then a capture strobe and a one-cycle done pulse.
module config_shift_engine #(
  parameter int unsigned NBYTES     = 12,
  parameter int unsigned CLKDIV     = 4,
  parameter int unsigned RST_CYCLES = 8
) (
  input  logic                  clkin,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  do_reset,
  input  logic [NBYTES*8-1:0]   cfg_data,
  output logic                  p_sck,
  output logic                  p_sda,
  output logic                  p_scapt,
  output logic                  p_reset,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NBITS   = NBYTES * 8;
  localparam int unsigned BCW     = $clog2(NBITS + 1);
  localparam int unsigned CNT_MAX = (CLKDIV > RST_CYCLES) ? CLKDIV : RST_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, RSTPULSE, SLOW, SHIGH, CAPT, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BCW-1:0]     bitcnt_q, bitcnt_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic               start_q;
  logic               p_sck_q, p_sda_q, p_scapt_q, p_reset_q, busy_q, done_q;
  logic               p_sck_d, p_sda_d, p_scapt_d, p_reset_d, busy_d, done_d;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      start_q   <= 1'b1;
      p_sck_q   <= 1'b0;
      p_sda_q   <= 1'b0;
      p_scapt_q <= 1'b0;
      p_reset_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      start_q   <= start;
      p_sck_q   <= p_sck_d;
      p_sda_q   <= p_sda_d;
      p_scapt_q <= p_scapt_d;
      p_reset_q <= p_reset_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state; cnt_q counts cycles spent in the current state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !start_q) begin
          shreg_d  = cfg_data;
          bitcnt_d = '0;
          state_d  = do_reset ? RSTPULSE : SLOW;
        end
      end
      RSTPULSE: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = SLOW;
          cnt_d   = '0;
        end
      end
      SLOW: begin
        if (cnt_q == CW'(CLKDIV - 1)) begin
          state_d = SHIGH;
          cnt_d   = '0;
        end
      end
      SHIGH: begin
        if (cnt_q == CW'(CLKDIV - 1)) begin
          shreg_d  = shreg_q << 1;
          bitcnt_d = bitcnt_q + BCW'(1);
          state_d  = (bitcnt_q == BCW'(NBITS - 1)) ? CAPT : SLOW;
          cnt_d    = '0;
        end
      end
      CAPT: begin
        if (cnt_q == CW'(CLKDIV - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the pins line up with state_q
  always_comb begin
    p_sck_d   = (state_d == SHIGH);
    p_sda_d   = ((state_d == SLOW) || (state_d == SHIGH)) && shreg_d[NBITS-1];
    p_scapt_d = (state_d == CAPT);
    p_reset_d = (state_d == RSTPULSE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  assign p_sck   = p_sck_q;
  assign p_sda   = p_sda_q;
  assign p_scapt = p_scapt_q;
  assign p_reset = p_reset_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_config_shift_engine.sv
// Scoreboard bench for config_shift_engine: stimulus queues expected frames,
// a monitor rebuilds each frame from the pins and checks it when done pulses.
module tb_config_shift_engine;

  localparam int unsigned NBYTES     = 12;
  localparam int unsigned CLKDIV     = 4;
  localparam int unsigned RST_CYCLES = 8;
  localparam int unsigned NBITS      = NBYTES * 8;
  localparam int unsigned LAT        = 2 * CLKDIV * NBITS + CLKDIV;

  logic             clkin;
  logic             rst;
  logic             start;
  logic             do_reset;
  logic [NBITS-1:0] cfg_data;
  logic             p_sck, p_sda, p_scapt, p_reset, busy, done;

  config_shift_engine #(
    .NBYTES(NBYTES), .CLKDIV(CLKDIV), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clkin(clkin), .rst(rst), .start(start), .do_reset(do_reset),
    .cfg_data(cfg_data), .p_sck(p_sck), .p_sda(p_sda), .p_scapt(p_scapt),
    .p_reset(p_reset), .busy(busy), .done(done)
  );

  typedef struct {
    logic [NBITS-1:0] data;
    bit               dr;
    int               edge_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc++;

  task automatic chk(input string nm, input logic [NBITS-1:0] got,
                     input logic [NBITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: rebuild the frame from the pins, compare when done pulses
  int               nedges, scapt_n, preset_n, preset_at_first;
  logic [NBITS-1:0] bits_got;
  logic             prev_sck, prev_done;

  always @(negedge clkin) begin
    if (rst) begin
      nedges = 0; scapt_n = 0; preset_n = 0; preset_at_first = 0;
      bits_got = '0; prev_sck = 1'b0; prev_done = 1'b0;
    end else begin
      chk("sck_outside_shift", NBITS'(p_sck & (p_scapt | p_reset | ~busy)), '0);
      if (p_sck && !prev_sck) begin
        if (nedges == 0) preset_at_first = preset_n;
        bits_got = {bits_got[NBITS-2:0], p_sda};
        nedges++;
      end
      if (p_scapt) scapt_n++;
      if (p_reset) preset_n++;
      if (done) begin
        exp_t e;
        int   rlen;
        chk("done_single_cycle", NBITS'(prev_done), '0);
        chk("pending_frames", NBITS'(sb.size()), NBITS'(1));
        if (sb.size() > 0) begin
          e    = sb.pop_front();
          rlen = e.dr ? int'(RST_CYCLES) : 0;
          chk("done_latency", NBITS'(cyc - e.edge_cyc), NBITS'(int'(LAT) + rlen));
          chk("sck_edges", NBITS'(nedges), NBITS'(NBITS));
          chk("sda_bits", bits_got, e.data);
          chk("scapt_len", NBITS'(scapt_n), NBITS'(CLKDIV));
          chk("preset_len", NBITS'(preset_n), NBITS'(rlen));
          chk("preset_before_sck", NBITS'(preset_at_first), NBITS'(rlen));
        end
        nedges = 0; scapt_n = 0; preset_n = 0; preset_at_first = 0; bits_got = '0;
      end
      prev_sck  = p_sck;
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic rand_cfg(output logic [NBITS-1:0] d);
    for (int i = 0; i < int'(NBYTES); i++) d[i*8 +: 8] = 8'($urandom);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_p_sck"},   NBITS'(p_sck),   '0);
    chk({tag, "_p_sda"},   NBITS'(p_sda),   '0);
    chk({tag, "_p_scapt"}, NBITS'(p_scapt), '0);
    chk({tag, "_p_reset"}, NBITS'(p_reset), '0);
    chk({tag, "_busy"},    NBITS'(busy),    '0);
    chk({tag, "_done"},    NBITS'(done),    '0);
  endtask

  // Issue one accepted start edge, then scramble the inputs behind it
  task automatic launch(input logic [NBITS-1:0] d, input bit dr);
    logic [NBITS-1:0] junk;
    start = 1'b0;
    tick();
    cfg_data = d;
    do_reset = dr;
    start    = 1'b1;
    sb.push_back('{d, dr, cyc + 1});
    tick();
    rand_cfg(junk);
    cfg_data = junk;
    do_reset = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < int'(LAT + RST_CYCLES) + 64; i++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_timeout", NBITS'(ok), NBITS'(1));
    repeat (3) tick();
    chk("no_extra_frame", NBITS'(busy), '0);
    chk("sb_drained", NBITS'(sb.size()), '0);
  endtask

  initial begin
    logic [NBITS-1:0] vec;
    logic [NBITS-1:0] d;
    bit               seen_busy;
    bit               got_done;
    int               n;

    vec      = 96'hFE8007_00F803_C00180_0F800C;
    rst      = 1'b0;
    start    = 1'b0;
    do_reset = 1'b0;
    cfg_data = '0;
    #1 rst = 1'b1;
    #1 outputs_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reference vector, without and with chip reset
    launch(vec, 1'b0);
    wait_idle();
    launch(vec, 1'b1);
    wait_idle();

    // Start edges while busy (mid-frame and in the done cycle) are dropped
    launch(vec, 1'b0);
    repeat (40 * 2 * CLKDIV) tick();
    rand_cfg(d);
    cfg_data = d;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < int'(LAT) + 64; i++) begin
      tick();
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    chk("done_seen", NBITS'(got_done), NBITS'(1));
    start = 1'b1;
    wait_idle();

    // Reset mid-frame aborts; a later start runs a full frame
    rand_cfg(d);
    launch(d, 1'b0);
    repeat (50 * 2 * CLKDIV) tick();
    rst = 1'b1;
    sb.delete();
    #1 outputs_zero("abort");
    tick();
    tick();
    start = 1'b0;
    rst = 1'b0;
    tick();
    rand_cfg(d);
    launch(d, 1'b1);
    wait_idle();

    // start held high through reset release must not launch a frame
    rst   = 1'b1;
    start = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    seen_busy = 1'b0;
    repeat (2000) begin
      tick();
      if (busy) seen_busy = 1'b1;
    end
    chk("held_start_no_frame", NBITS'(seen_busy), '0);
    rand_cfg(d);
    launch(d, 1'b0);
    wait_idle();

    // Randomized frames with start chatter during the frame
    for (int f = 0; f < 6; f++) begin
      rand_cfg(d);
      launch(d, 1'($urandom_range(0, 1)));
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(1, 100)) tick();
        start = ~start;
      end
      start = 1'b0;
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
